seven_segment_to_binary: RTL and testbench

Monitor and decoder for a multiplexed 4-digit, active-low 7-segment display bus. It samples the anode and segment lines, filters out transition glitches, and decodes each stable segment pattern back to a hex nibble. It reassembles the four digits into the 16-bit word that was being displayed. It sits on the display pins, alongside or downstream of the display driver, and provides loop-back checking and display capture.

---
 rtl/seven_segment_pkg.sv | 49 ++++
 rtl/seg_pattern_decode.sv | 41 ++++
 rtl/seven_segment_to_binary.sv | 151 +++++++++++++++
 tb/tb_seven_segment_to_binary.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared constants for the multiplexed 7-segment display bus: segment patterns,
// anode selects, and the frame-capture FSM state type.
package seven_segment_pkg;

  // Active-low segment patterns {g,f,e,d,c,b,a}, shared with the display driver.
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_DIGIT0 = 4'b1110;
  localparam logic [3:0] AN_DIGIT1 = 4'b1101;
  localparam logic [3:0] AN_DIGIT2 = 4'b1011;
  localparam logic [3:0] AN_DIGIT3 = 4'b0111;
  localparam logic [3:0] AN_BLANK  = 4'b1111;

  typedef enum logic {
    SEARCH  = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Replace nibble i (0..2) of the partial-frame shadow; index 3 never lands here.
  function automatic logic [11:0] put_nibble(input logic [11:0] word,
                                             input logic [1:0]  idx,
                                             input logic [3:0]  nib);
    logic [11:0] result;
    result = word;
    case (idx)
      2'd0:    result[3:0]  = nib;
      2'd1:    result[7:4]  = nib;
      default: result[11:8] = nib;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational decode of an active-low segment pattern to a hex nibble.
// BCD_ONLY_EN restricts the legal set to digits 0-9.
module seg_pattern_decode (
  input  logic [6:0] seg,
  output logic       hit,
  output logic [3:0] nibble
);
  import seven_segment_pkg::*;

  always_comb begin
    hit    = 1'b1;
    nibble = 4'h0;
    case (seg)
      SEG_0: nibble = 4'h0;
      SEG_1: nibble = 4'h1;
      SEG_2: nibble = 4'h2;
      SEG_3: nibble = 4'h3;
      SEG_4: nibble = 4'h4;
      SEG_5: nibble = 4'h5;
      SEG_6: nibble = 4'h6;
      SEG_7: nibble = 4'h7;
      SEG_8: nibble = 4'h8;
      SEG_9: nibble = 4'h9;
      SEG_A: nibble = 4'hA;
      SEG_B: nibble = 4'hB;
      SEG_C: nibble = 4'hC;
      SEG_D: nibble = 4'hD;
      SEG_E: nibble = 4'hE;
      SEG_F: nibble = 4'hF;
      default: hit  = 1'b0;
    endcase
`ifdef BCD_ONLY_EN
    if (nibble > 4'd9) begin
      hit    = 1'b0;
      nibble = 4'h0;
    end
`else
`endif
  end

endmodule

// File: rtl/seven_segment_to_binary.sv
// Monitors a multiplexed 4-digit active-low 7-segment bus and rebuilds the
// displayed 16-bit word. Optional BCD_ONLY_EN limits accepted digits to 0-9.
module seven_segment_to_binary #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] data,
  output logic        data_valid,
  output logic        digit_err,
  output logic        frame_err,
  output logic [7:0]  err_count
);
  import seven_segment_pkg::*;

  localparam logic [7:0] ACCEPT_AT = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CNT_MAX   = 8'(STABLE_CYCLES);

  logic [10:0] s_q, s_d;
  logic [7:0]  stab_cnt_q, stab_cnt_d;
  state_t      state_q, state_d;
  logic [1:0]  exp_q, exp_d;
  logic [11:0] shadow_q, shadow_d;
  logic [15:0] data_q, data_d;
  logic        data_valid_q, data_valid_d;
  logic        digit_err_q, digit_err_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  err_count_q, err_count_d;

  logic        hold, accept;
  logic        seg_hit;
  logic [3:0]  seg_nib;
  logic        an_valid, an_blank;
  logic [1:0]  idx;

  seg_pattern_decode u_decode (
    .seg    (s_q[6:0]),
    .hit    (seg_hit),
    .nibble (seg_nib)
  );

  assign hold   = ({an, seg} == s_q);
  assign accept = hold && (stab_cnt_q == ACCEPT_AT);

  always_comb begin
    an_valid = 1'b1;
    an_blank = 1'b0;
    idx      = 2'd0;
    case (s_q[10:7])
      AN_DIGIT0: idx = 2'd0;
      AN_DIGIT1: idx = 2'd1;
      AN_DIGIT2: idx = 2'd2;
      AN_DIGIT3: idx = 2'd3;
      AN_BLANK:  an_blank = 1'b1;
      default:   an_valid = 1'b0;
    endcase
  end

  always_comb begin
    s_d          = {an, seg};
    state_d      = state_q;
    exp_d        = exp_q;
    shadow_d     = shadow_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    digit_err_d  = 1'b0;
    frame_err_d  = 1'b0;

    // Counter parks one past the accept point so a long run is accepted only once.
    if (!hold)
      stab_cnt_d = 8'd0;
    else if (stab_cnt_q == CNT_MAX)
      stab_cnt_d = stab_cnt_q;
    else
      stab_cnt_d = stab_cnt_q + 8'd1;

    if (accept && !an_blank) begin
      if (!an_valid || !seg_hit) begin
        digit_err_d = 1'b1;
        state_d     = SEARCH;
        exp_d       = 2'd0;
      end else if (state_q == SEARCH) begin
        if (idx == 2'd0) begin
          shadow_d = put_nibble(shadow_q, 2'd0, seg_nib);
          exp_d    = 2'd1;
          state_d  = COLLECT;
        end
      end else if (idx == exp_q) begin
        if (idx == 2'd3) begin
          data_d       = {seg_nib, shadow_q};
          data_valid_d = 1'b1;
          state_d      = SEARCH;
          exp_d        = 2'd0;
        end else begin
          shadow_d = put_nibble(shadow_q, idx, seg_nib);
          exp_d    = exp_q + 2'd1;
        end
      end else if (idx == exp_q - 2'd1) begin
        shadow_d = put_nibble(shadow_q, idx, seg_nib);
      end else if (idx == 2'd0) begin
        frame_err_d = 1'b1;
        shadow_d    = put_nibble(shadow_q, 2'd0, seg_nib);
        exp_d       = 2'd1;
      end else begin
        frame_err_d = 1'b1;
        state_d     = SEARCH;
        exp_d       = 2'd0;
      end
    end

    if ((digit_err_d || frame_err_d) && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'd1;
    else
      err_count_d = err_count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q          <= {AN_BLANK, SEG_BLANK};
      stab_cnt_q   <= 8'd0;
      state_q      <= SEARCH;
      exp_q        <= 2'd0;
      shadow_q     <= 12'h000;
      data_q       <= 16'h0000;
      data_valid_q <= 1'b0;
      digit_err_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      err_count_q  <= 8'd0;
    end else begin
      s_q          <= s_d;
      stab_cnt_q   <= stab_cnt_d;
      state_q      <= state_d;
      exp_q        <= exp_d;
      shadow_q     <= shadow_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      digit_err_q  <= digit_err_d;
      frame_err_q  <= frame_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign digit_err  = digit_err_q;
  assign frame_err  = frame_err_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_seven_segment_to_binary.sv
// Scoreboard bench for seven_segment_to_binary: frames pushed as they are
// driven, popped when data_valid fires; error pulses counted by a monitor.
module tb_seven_segment_to_binary;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] data;
  logic        data_valid;
  logic        digit_err;
  logic        frame_err;
  logic [7:0]  err_count;

  int vectors     = 0;
  int miscompares = 0;
  int valid_seen  = 0;
  int derr_seen   = 0;
  int ferr_seen   = 0;
  int exp_err     = 0;
  logic [15:0] exp_frames[$];
  logic [15:0] sb_exp;

  seven_segment_to_binary #(.STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .an         (an),
    .seg        (seg),
    .data       (data),
    .data_valid (data_valid),
    .digit_err  (digit_err),
    .frame_err  (frame_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  // Scoreboard side: every data_valid must match the oldest frame still expected.
  always @(negedge clk) begin
    if (data_valid) begin
      valid_seen++;
      vectors++;
      if (exp_frames.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_valid: data=%h with no frame expected", data);
      end else begin
        sb_exp = exp_frames.pop_front();
        if (data !== sb_exp) begin
          miscompares++;
          $display("[TB] FAIL frame_data: got %h expected %h", data, sb_exp);
        end
      end
    end
    if (digit_err) derr_seen++;
    if (frame_err) ferr_seen++;
  end

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [3:0] an_of(input int i);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << i;
    return ~one_hot;
  endfunction

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int cycles);
    an  = a;
    seg = s;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_digit(input logic [15:0] w, input int i, input int cycles);
    drive(an_of(i), seg_of(w[4*i +: 4]), cycles);
  endtask

  task automatic send_frame(input logic [15:0] w);
    for (int i = 0; i < 4; i++) send_digit(w, i, 10);
    drive(4'b1111, 7'b1111111, 6);
  endtask

  task automatic check_counts(input string name, input int dv, input int dd,
                              input int df, input int v0, input int d0, input int f0);
    vectors++;
    if (valid_seen - v0 !== dv || derr_seen - d0 !== dd || ferr_seen - f0 !== df) begin
      miscompares++;
      $display("[TB] FAIL %s_pulses: got valid=%0d digit_err=%0d frame_err=%0d expected %0d/%0d/%0d",
               name, valid_seen - v0, derr_seen - d0, ferr_seen - f0, dv, dd, df);
    end
    vectors++;
    if (err_count !== 8'(exp_err)) begin
      miscompares++;
      $display("[TB] FAIL %s_err_count: got %0d expected %0d", name, err_count, exp_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    an  = 4'b1111;
    seg = 7'b1111111;
    repeat (2) @(negedge clk);
    vectors++;
    if ({data, data_valid, digit_err, frame_err, err_count} !== 27'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got data=%h dv=%b de=%b fe=%b ec=%0d expected all 0",
               data, data_valid, digit_err, frame_err, err_count);
    end
    rst = 1'b0;
    drive(4'b1111, 7'b1111111, 6);
  endtask

  task automatic test_frame_1234();
    int v0, d0, f0, lat;
    v0 = valid_seen; d0 = derr_seen; f0 = ferr_seen;
    exp_frames.push_back(16'h1234);
    for (int i = 0; i < 3; i++) send_digit(16'h1234, i, 10);
    an  = an_of(3);
    seg = seg_of(4'h1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (data_valid && lat == 0) lat = i;
    end
    vectors++;
    if (lat !== 5) begin
      miscompares++;
      $display("[TB] FAIL frame_latency: got %0d cycles expected 5", lat);
    end
    drive(4'b1111, 7'b1111111, 6);
    check_counts("frame_1234", 1, 0, 0, v0, d0, f0);
  endtask

  task automatic test_glitch();
    int v0, d0, f0;
    v0 = valid_seen; d0 = derr_seen; f0 = ferr_seen;
    exp_frames.push_back(16'h1234);
    send_digit(16'h1234, 0, 10);
    send_digit(16'h1234, 1, 10);
    drive(an_of(2), 7'b0000000, 2);
    send_digit(16'h1234, 2, 10);
    send_digit(16'h1234, 3, 10);
    drive(4'b1111, 7'b1111111, 6);
    check_counts("glitch", 1, 0, 0, v0, d0, f0);
  endtask

  task automatic test_bad_segment();
    int v0, d0, f0;
    v0 = valid_seen; d0 = derr_seen; f0 = ferr_seen;
    drive(an_of(0), 7'b1111111, 8);
    drive(4'b1111, 7'b1111111, 6);
    exp_err++;
    check_counts("bad_segment", 0, 1, 0, v0, d0, f0);
  endtask

  task automatic test_out_of_order();
    int v0, d0, f0;
    v0 = valid_seen; d0 = derr_seen; f0 = ferr_seen;
    send_digit(16'hBEEF, 0, 10);
    send_digit(16'hBEEF, 1, 10);
    send_digit(16'hBEEF, 3, 10);
    exp_err++;
    check_counts("out_of_order", 0, 0, 1, v0, d0, f0);
    v0 = valid_seen; d0 = derr_seen; f0 = ferr_seen;
    exp_frames.push_back(16'hBEEF);
    send_frame(16'hBEEF);
    check_counts("in_order_beef", 1, 0, 0, v0, d0, f0);
  endtask

  task automatic test_hex_digits();
    int v0, d0, f0;
    v0 = valid_seen; d0 = derr_seen; f0 = ferr_seen;
`ifdef BCD_ONLY_EN
    send_frame(16'hA987);
    exp_err++;
    check_counts("bcd_reject_a", 0, 1, 0, v0, d0, f0);
`else
    exp_frames.push_back(16'hA987);
    send_frame(16'hA987);
    check_counts("hex_a987", 1, 0, 0, v0, d0, f0);
`endif
  endtask

  task automatic test_reset_mid_frame();
    int v0, d0, f0;
    send_digit(16'h5678, 0, 10);
    send_digit(16'h5678, 1, 10);
    rst = 1'b1;
    #1;
    vectors++;
    if ({data, data_valid, digit_err, frame_err, err_count} !== 27'd0) begin
      miscompares++;
      $display("[TB] FAIL midframe_reset: got data=%h dv=%b de=%b fe=%b ec=%0d expected all 0",
               data, data_valid, digit_err, frame_err, err_count);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_err = 0;
    v0 = valid_seen; d0 = derr_seen; f0 = ferr_seen;
    send_digit(16'h5678, 2, 10);
    send_digit(16'h5678, 3, 10);
    drive(4'b1111, 7'b1111111, 6);
    check_counts("after_reset", 0, 0, 0, v0, d0, f0);
    vectors++;
    if (data !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL after_reset_data: got %h expected 0000", data);
    end
  endtask

  task automatic test_err_saturation();
    int v0, d0, f0;
    v0 = valid_seen; d0 = derr_seen; f0 = ferr_seen;
    for (int i = 0; i < 260; i++) begin
      drive(4'b1100, seg_of(4'h3), 5);
      drive(4'b1111, 7'b1111111, 5);
      if (exp_err < 255) exp_err++;
    end
    check_counts("err_saturation", 0, 260, 0, v0, d0, f0);
  endtask

  initial begin
    test_reset();
    test_frame_1234();
    test_glitch();
    test_bad_segment();
    test_out_of_order();
    test_hex_digits();
    test_reset_mid_frame();
    test_err_saturation();
    vectors++;
    if (exp_frames.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL missing_frames: %0d expected frames never reported", exp_frames.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
